// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
// Shares one byte-wide RAM port between instruction fetch (IF) and the
// load/store stage (MEM). A request of N bytes (1, 2 or 4; fetches are always
// 4) is sequenced as N back-to-back byte accesses. The little-endian result
// goes back to the winning requester together with a one-cycle done pulse.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   rdy_in              global enable; low freezes every register
//   if_req/if_addr      fetch request (level) and byte address
//   if_flush            abort the current or pending fetch
//   if_done/if_inst     fetch done pulse and fetched word
//   mem_req/mem_wr      load/store request (level), 1 = store
//   mem_len/mem_addr    size (0 byte, 1 half, 2/3 word) and byte address
//   mem_wdata           store data, byte k at bits [8k+7:8k]
//   mem_done/mem_rdata  load/store done pulse and zero-extended load data
//   ram_din             RAM read data for the address currently on ram_a
//   ram_dout/ram_a/ram_wr  RAM write data, byte address, write enable
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy_in,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_done,
   output logic [31:0]       if_inst,
   input  logic              mem_req,
   input  logic              mem_wr,
   input  logic [1:0]        mem_len,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_done,
   output logic [31:0]       mem_rdata,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_e;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;       // next byte index to present (1..N)
   logic [2:0]        len_q, len_d;       // transfer size in bytes
   logic [ADDR_W-1:0] base_q, base_d;
   logic              wr_q, wr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       buf_q, buf_d;       // bytes collected so far
   logic [ADDR_W-1:0] ram_a_q, ram_a_d;
   logic              ram_wr_q, ram_wr_d;
   logic [7:0]        ram_dout_q, ram_dout_d;
   logic              if_done_q, if_done_d;
   logic [31:0]       if_inst_q, if_inst_d;
   logic              mem_done_q, mem_done_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;

   logic              last;               // this edge captures the final byte
   logic [2:0]        byte_idx;
   logic [31:0]       rd_buf;             // buffer with the current ram_din merged in
   logic [7:0]        st_byte;            // store byte for the address about to be presented

   function automatic logic [2:0] len_bytes(input logic [1:0] l);
      case (l)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   assign last     = (cnt_q == len_q);
   assign byte_idx = cnt_q - 3'd1;

   always_comb begin
      rd_buf = buf_q;
      for (int i = 0; i < 4; i++) begin
         if (byte_idx == 3'(i)) rd_buf[8*i +: 8] = ram_din;
      end
   end

   always_comb begin
      case (cnt_q[1:0])
         2'd1:    st_byte = wdata_q[15:8];
         2'd2:    st_byte = wdata_q[23:16];
         2'd3:    st_byte = wdata_q[31:24];
         default: st_byte = wdata_q[7:0];
      endcase
   end

   // State register plus datapath registers. A low rdy_in holds everything.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         base_q      <= '0;
         wr_q        <= 1'b0;
         wdata_q     <= '0;
         buf_q       <= '0;
         ram_a_q     <= '0;
         ram_wr_q    <= 1'b0;
         ram_dout_q  <= '0;
         if_done_q   <= 1'b0;
         if_inst_q   <= '0;
         mem_done_q  <= 1'b0;
         mem_rdata_q <= '0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         base_q      <= base_d;
         wr_q        <= wr_d;
         wdata_q     <= wdata_d;
         buf_q       <= buf_d;
         ram_a_q     <= ram_a_d;
         ram_wr_q    <= ram_wr_d;
         ram_dout_q  <= ram_dout_d;
         if_done_q   <= if_done_d;
         if_inst_q   <= if_inst_d;
         mem_done_q  <= mem_done_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // Next state. A done pulse still high blocks arbitration, which forces one
   // idle cycle between transfers; MEM has priority over IF.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!(if_done_q || mem_done_q)) begin
               if (mem_req)                  state_d = BUSY_MEM;
               else if (if_req && !if_flush) state_d = BUSY_IF;
            end
         end
         BUSY_IF:  if (if_flush || last) state_d = IDLE;
         BUSY_MEM: if (last)             state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Next values of the datapath and output registers.
   // NOTE: every variable gets a default first so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      cnt_d       = cnt_q;
      len_d       = len_q;
      base_d      = base_q;
      wr_d        = wr_q;
      wdata_d     = wdata_q;
      buf_d       = buf_q;
      ram_a_d     = ram_a_q;
      ram_wr_d    = ram_wr_q;
      ram_dout_d  = ram_dout_q;
      if_done_d   = 1'b0;
      if_inst_d   = if_inst_q;
      mem_done_d  = 1'b0;
      mem_rdata_d = mem_rdata_q;

      case (state_q)
         IDLE: begin
            if (state_d == BUSY_MEM) begin
               base_d   = mem_addr;
               len_d    = len_bytes(mem_len);
               wr_d     = mem_wr;
               wdata_d  = mem_wdata;
               buf_d    = '0;
               cnt_d    = 3'd1;
               ram_a_d  = mem_addr;
               ram_wr_d = mem_wr;
               if (mem_wr) ram_dout_d = mem_wdata[7:0];
            end else if (state_d == BUSY_IF) begin
               base_d  = if_addr;
               len_d   = 3'd4;
               wr_d    = 1'b0;
               buf_d   = '0;
               cnt_d   = 3'd1;
               ram_a_d = if_addr;
            end
         end
         default: begin
            if (state_q == BUSY_IF && if_flush) begin
               // Redirected fetch: drop the partial word silently.
               cnt_d    = '0;
               buf_d    = '0;
               ram_a_d  = '0;
               ram_wr_d = 1'b0;
            end else begin
               if (!wr_q) buf_d = rd_buf;
               if (last) begin
                  cnt_d    = '0;
                  ram_a_d  = '0;
                  ram_wr_d = 1'b0;
                  if (state_q == BUSY_IF) begin
                     if_done_d = 1'b1;
                     if_inst_d = rd_buf;
                  end else begin
                     mem_done_d = 1'b1;
                     if (!wr_q) mem_rdata_d = rd_buf;
                  end
               end else begin
                  cnt_d   = cnt_q + 3'd1;
                  ram_a_d = base_q + ADDR_W'(cnt_q);   // wraps modulo 2^ADDR_W
                  if (wr_q) ram_dout_d = st_byte;
               end
            end
         end
      endcase
   end

   assign if_done   = if_done_q;
   assign if_inst   = if_inst_q;
   assign mem_done  = mem_done_q;
   assign mem_rdata = mem_rdata_q;
   assign ram_dout  = ram_dout_q;
   assign ram_a     = ram_a_q;
   assign ram_wr    = ram_wr_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Sequences multi-byte transfers (1/2/4 bytes) as back-to-back byte accesses.
- Returns a whole little-endian word to the winning requester with a one-cycle done pulse.
- Sits between the IF/MEM pipeline stages and the RAM; its fetched words feed the decode stage.

Parameters:
- ADDR_W, 32, width of all byte addresses (matches the codebase address length).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- rdy_in  input  1  global enable; low freezes all state and outputs
- if_req  input  1  fetch request (level)
- if_addr  input  ADDR_W  fetch byte address
- if_flush  input  1  abort the current or pending fetch (branch redirect)
- if_done  output  1  one-cycle pulse; if_inst is valid
- if_inst  output  32  fetched instruction, little-endian
- mem_req  input  1  load/store request (level)
- mem_wr  input  1  1 = store, 0 = load
- mem_len  input  2  0 = byte, 1 = half, 2 or 3 = word
- mem_addr  input  ADDR_W  load/store byte address
- mem_wdata  input  32  store data; byte k = bits [8k+7:8k]
- mem_done  output  1  one-cycle pulse; load data valid or store complete
- mem_rdata  output  32  load data, zero-extended (sign extension is done by the MEM stage)
- ram_din  input  8  RAM read data; valid one cycle after ram_a is presented
- ram_dout  output  8  RAM write data
- ram_a  output  ADDR_W  RAM byte address
- ram_wr  output  1  1 = write, 0 = read

Behaviour:
- All outputs are registered.
- Reset (async): state IDLE, counter 0, every output 0, internal byte buffer 0.
- Reset mid-transfer aborts the transfer. No done is issued. Bytes already written stay in RAM.
- rdy_in = 0: no register changes at that edge (full stall). The transfer resumes unchanged when rdy_in returns to 1.
- States: IDLE, BUSY_IF, BUSY_MEM. N = 1, 2 or 4 bytes (IF is always 4).
- Arbitration in IDLE:
  - Requests are ignored at any edge where if_done or mem_done is currently 1. This guarantees one idle cycle after each done.
  - Otherwise mem_req wins over if_req.
  - if_req is ignored while if_flush is 1.
- Accept edge E0:
  - Latch the base address, N and the type.
  - ram_a <= base; counter <= 1.
  - Store: ram_wr <= 1 and ram_dout <= byte 0.
- Edge Ek, 1 <= k <= N-1:
  - Load/fetch: buffer byte k-1 <= ram_din.
  - Store: ram_dout <= byte k.
  - ram_a <= base + k; counter increments.
- Edge EN:
  - Load/fetch: buffer byte N-1 <= ram_din.
  - Pulse the requester's done for exactly one cycle with the data; unused upper bytes are 0.
  - ram_wr <= 0, ram_a <= 0, return to IDLE.
- Latency: done rises at edge N after acceptance. A word fetch takes 4 edges, plus 1 mandatory idle cycle before the next accept.
- Requester obligations:
  - Hold req and all fields stable until done is seen.
  - Drop req, or present a new request, in the cycle done is high.
- Address arithmetic: base + k wraps modulo 2^ADDR_W. No alignment check; a misaligned word is fetched bytewise as-is.
- if_flush:
  - In BUSY_IF: the next edge returns to IDLE with no if_done, ram_a <= 0 and a discarded buffer.
  - In BUSY_MEM or IDLE: drops any IF request; an in-flight MEM transfer is never affected.
- A simultaneous if_flush and a new if_req in the same cycle discards the request.
- The done outputs and the data outputs hold their last data when done is 0. Data is only meaningful while done = 1.

Test Plan:
- Fetch: RAM[0x1000..0x1003] = 13 05 10 00; if_req with if_addr 0x1000 -> if_done 4 edges after accept, if_inst 0x00100513; ram_a steps 0x1000..0x1003.
- Conflict: if_req and mem_req (load word, 0x2000 = 78 56 34 12) rise together -> mem_done with mem_rdata 0x12345678 first; one idle cycle; then the fetch starts.
- Store half: mem_wr = 1, len 1, addr 0x3001, wdata 0xAABBCCDD -> ram_wr high 2 cycles, writing DD@0x3001 and CC@0x3002; mem_done at edge 2; ram_wr 0 afterwards.
- Load byte 0x80 at 0x4000 -> mem_rdata 0x00000080, mem_done at edge 1 after accept.
- Flush after 2 bytes of a fetch -> no if_done; IDLE next edge; a new fetch at 0x5000 completes normally.
- rdy_in low for 3 cycles mid-fetch -> ram_a and the counter frozen, result unchanged, done delayed 3 cycles. Async rst mid-store -> all outputs 0 immediately, no mem_done.
